logic_unit_pipe: RTL and testbench



---
 rtl/logic_ops_pkg.sv | 40 ++++
 rtl/logic_sweep_engine.sv | 81 ++++++++
 rtl/logic_unit_pipe.sv | 104 ++++++++++
 tb/tb_logic_unit_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_ops_pkg.sv
// Shared definitions for the logic unit: op encoding, op width, sweep FSM
// state type and the single-bit logic function used by both the result
// pipeline and the sweep engine.
package logic_ops_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_DONE = 2'd2
  } sweep_state_t;

  // All ops are bitwise, so one bit is enough; callers loop over the width.
  // This keeps the function independent of WIDTH.
  function automatic logic logic_op(input logic [OP_W-1:0] op,
                                    input logic a,
                                    input logic b);
    case (op)
      OP_AND:  logic_op = a & b;
      OP_OR:   logic_op = a | b;
      OP_NOT:  logic_op = ~a;
      OP_NAND: logic_op = ~(a & b);
      OP_NOR:  logic_op = ~(a | b);
      OP_XOR:  logic_op = a ^ b;
      OP_XNOR: logic_op = ~(a ^ b);
      default: logic_op = a;  // OP_PASS
    endcase
  endfunction

endpackage

// File: rtl/logic_sweep_engine.sv
// Exhaustive operand sweep: walks {a_s,b_s} from 0 to all-ones through the
// latched op and folds each result into a rotate-xor signature.
// WIDTH must be 1..8 (the counter is 2*WIDTH bits wide).
// FSM state is exposed on o_state; the parent decodes busy/done from it.
module logic_sweep_engine
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_op,
  output logic [1:0]       o_state,
  output logic [WIDTH-1:0] o_sig
);

  sweep_state_t       r_state;
  sweep_state_t       w_next;
  logic [OP_W-1:0]    r_op;
  logic [2*WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sig;
  logic [WIDTH-1:0]   w_a_s;
  logic [WIDTH-1:0]   w_b_s;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_rot;
  logic               w_last;

  assign w_a_s  = r_cnt[2*WIDTH-1:WIDTH];
  assign w_b_s  = r_cnt[WIDTH-1:0];
  assign w_last = &r_cnt;
  // Rotate left by one; for WIDTH=1 this degenerates to the identity.
  assign w_rot  = (r_sig << 1) | (r_sig >> (WIDTH-1));

  // Result of the latched op on the current counter operands.
  always_comb begin
    w_r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_r[i] = logic_op(r_op, w_a_s[i], w_b_s[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SW_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: IDLE -> RUN on start, RUN -> DONE after the last count,
  // DONE -> IDLE after a single cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SW_IDLE: if (i_start) w_next = SW_RUN;
      SW_RUN:  if (w_last)  w_next = SW_DONE;
      SW_DONE: w_next = SW_IDLE;
      default: w_next = SW_IDLE;
    endcase
  end

  // Datapath: latch op and clear counter/signature on start, then fold one
  // result per RUN cycle. The signature is otherwise held for readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_cnt <= '0;
      r_sig <= '0;
    end else if (r_state == SW_IDLE && i_start) begin
      r_op  <= i_op;
      r_cnt <= '0;
      r_sig <= '0;
    end else if (r_state == SW_RUN) begin
      r_sig <= w_rot ^ w_r;
      r_cnt <= r_cnt + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_state = r_state;
  assign o_sig   = r_sig;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise logic unit with a one-stage valid/ready output.
// Optional exhaustive sweep engine compiled in with LOGIC_UNIT_SWEEP_EN
// (WIDTH limited to 1..8 in that build).
//
// Handshake: a beat moves when valid && ready on the same rising edge.
// in_ready = !sweep_busy && (!out_valid || out_ready), so a full output
// stage can take a new beat in the cycle it drains. While out_valid is high
// and out_ready is low, y and y_op hold.
module logic_unit_pipe
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [OP_W-1:0]  y_op,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] sweep_sig
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [OP_W-1:0]  r_y_op;
  logic [WIDTH-1:0] w_f;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_sig;

  // Bitwise op on the incoming operands.
  always_comb begin
    w_f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_f[i] = logic_op(op, a[i], b[i]);
    end
  end

`ifdef LOGIC_UNIT_SWEEP_EN
  logic [1:0] w_sweep_state;
  logic       w_start_ok;

  // A start only counts with an empty output stage and no coincident
  // accept; the accept wins because it is about to fill the output.
  assign w_start_ok = sweep_start && !r_out_valid && !w_accept;

  logic_sweep_engine #(.WIDTH(WIDTH)) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start_ok),
    .i_op    (op),
    .o_state (w_sweep_state),
    .o_sig   (w_sig)
  );

  assign w_busy     = (sweep_state_t'(w_sweep_state) == SW_RUN);
  assign w_done     = (sweep_state_t'(w_sweep_state) == SW_DONE);
  assign w_in_ready = !w_busy && (!r_out_valid || out_ready);
`else
  logic w_sweep_start_unused;

  assign w_sweep_start_unused = sweep_start;
  assign w_busy     = 1'b0;
  assign w_done     = 1'b0;
  assign w_sig      = '0;
  assign w_in_ready = !r_out_valid || out_ready;
`endif

  assign w_accept = in_valid && w_in_ready;

  // Output stage: load on accept, drop valid when drained without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_op      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_f;
      r_y_op      <= op;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign y          = r_y;
  assign y_op       = r_y_op;
  assign sweep_busy = w_busy;
  assign sweep_done = w_done;
  assign sweep_sig  = w_sig;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a WIDTH=4 instance for the op table,
// backpressure and reset checks, and a WIDTH=1 instance for sweep checks
// (sweep behaviour when built with LOGIC_UNIT_SWEEP_EN, tied-off outputs
// otherwise).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;

  // WIDTH=4 instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b, y, sweep_sig;
  logic [2:0] op, y_op;
  logic       sweep_start, sweep_busy, sweep_done;

  // WIDTH=1 instance
  logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1;
  logic [0:0] a_1, b_1, y_1, sweep_sig_1;
  logic [2:0] op_1, y_op_1;
  logic       sweep_start_1, sweep_busy_1, sweep_done_1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_y[8];

  logic_unit_pipe #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_op(y_op),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .sweep_sig(sweep_sig)
  );

  logic_unit_pipe #(.WIDTH(1)) u_dut_1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .a(a_1), .b(b_1), .op(op_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .y(y_1), .y_op(y_op_1),
    .sweep_start(sweep_start_1), .sweep_busy(sweep_busy_1),
    .sweep_done(sweep_done_1), .sweep_sig(sweep_sig_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // count consecutive cycles with sweep_busy_1 high, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (sweep_busy_1 && n < 64) begin
      n++;
      step();
    end
  endtask

  // run one sweep on the WIDTH=1 instance and check length/done/signature
  task automatic run_sweep_1(input string tag, input logic [2:0] sop, input logic exp_sig);
    int n;
    op_1 = sop;
    sweep_start_1 = 1'b1;
    step();
    sweep_start_1 = 1'b0;
    count_busy(n);
    check({tag, "_busy_len"}, n, 4);
    check({tag, "_done"}, sweep_done_1, 1'b1);
    check({tag, "_sig"}, sweep_sig_1, exp_sig);
    step();
    check({tag, "_done_clr"}, sweep_done_1, 1'b0);
    check({tag, "_sig_hold"}, sweep_sig_1, exp_sig);
  endtask

  initial begin
    int n;
    exp_y[0] = 4'b1000; exp_y[1] = 4'b1110; exp_y[2] = 4'b0011; exp_y[3] = 4'b0111;
    exp_y[4] = 4'b0001; exp_y[5] = 4'b0110; exp_y[6] = 4'b1001; exp_y[7] = 4'b1100;

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0; sweep_start = 0;
    in_valid_1 = 0; out_ready_1 = 0; a_1 = 0; b_1 = 0; op_1 = 0; sweep_start_1 = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_y_op", y_op, 0);
    check("rst_busy", sweep_busy, 0);
    check("rst_done", sweep_done, 0);
    check("rst_sig", sweep_sig, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // op table, full throughput
    a = 4'b1100; b = 4'b1010; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; op = 3'(i);
      step();
      check($sformatf("op%0d_valid", i), out_valid, 1);
      check($sformatf("op%0d_y", i), y, exp_y[i]);
      check($sformatf("op%0d_y_op", i), y_op, i);
    end
    in_valid = 0;
    step();
    check("drain_valid", out_valid, 0);

    // backpressure: NAND beat then stall with in_valid held
    out_ready = 0; in_valid = 1; op = 3'd3;
    step();
    check("bp_y", y, 4'b0111);
    op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
      step();
      check($sformatf("bp_y_hold%0d", i), y, 4'b0111);
      check($sformatf("bp_y_op_hold%0d", i), y_op, 3'd3);
      check($sformatf("bp_valid_hold%0d", i), out_valid, 1);
    end
    out_ready = 1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    step();
    check("bp_next_y", y, 4'b1000);
    check("bp_next_y_op", y_op, 0);
    check("bp_next_valid", out_valid, 1);
    in_valid = 0;
    step();
    check("bp_drain", out_valid, 0);

`ifdef LOGIC_UNIT_SWEEP_EN
    out_ready_1 = 1;
    run_sweep_1("sw_and", 3'd0, 1'b1);
    run_sweep_1("sw_xor", 3'd5, 1'b0);

    // start while output full is ignored
    out_ready_1 = 0; in_valid_1 = 1; op_1 = 3'd1;
    step();
    in_valid_1 = 0; sweep_start_1 = 1;
    step();
    sweep_start_1 = 0;
    check("sw_full_ignored", sweep_busy_1, 0);
    out_ready_1 = 1;
    step();
    check("sw_full_drain", out_valid_1, 0);

    // start while busy is ignored (OR sweep: results 0,1,1,1)
    op_1 = 3'd1; sweep_start_1 = 1;
    step();
    sweep_start_1 = 0;
    step();
    sweep_start_1 = 1;
    step();
    sweep_start_1 = 0;
    count_busy(n);
    check("sw_rebusy_len", n, 2);
    check("sw_rebusy_sig", sweep_sig_1, 1'b1);
    step();
    step();
    check("sw_rebusy_idle", sweep_busy_1, 0);

    // coincident start and accept: accept wins
    in_valid_1 = 1; sweep_start_1 = 1; a_1 = 1; b_1 = 0; op_1 = 3'd1;
    step();
    in_valid_1 = 0; sweep_start_1 = 0;
    check("coinc_valid", out_valid_1, 1);
    check("coinc_y", y_1, 1'b1);
    check("coinc_busy", sweep_busy_1, 0);
    step();
    check("coinc_drain", out_valid_1, 0);

    // reset mid-sweep on W=1 and mid-stall on W=4
    out_ready = 0; in_valid = 1; op = 3'd7; a = 4'b0101;
    op_1 = 3'd0; sweep_start_1 = 1;
    step();
    in_valid = 0; sweep_start_1 = 0;
    step();
    check("pre_rst_busy", sweep_busy_1, 1);
    check("pre_rst_stall", out_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", sweep_busy_1, 0);
    check("mid_rst_done", sweep_done_1, 0);
    check("mid_rst_sig", sweep_sig_1, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_y_op", y_op, 0);
    step();
    rst = 0;
    out_ready = 1;
    #1;
    // NAND on W=1: results 1,1,1,0
    run_sweep_1("sw_after_rst", 3'd3, 1'b1);
`else
    // no sweep logic: starts have no effect
    out_ready_1 = 1; op_1 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      sweep_start_1 = 1;
      step();
      sweep_start_1 = 0;
      check($sformatf("nosw_busy%0d", i), sweep_busy_1, 0);
      check($sformatf("nosw_done%0d", i), sweep_done_1, 0);
      check($sformatf("nosw_sig%0d", i), sweep_sig_1, 0);
      check($sformatf("nosw_in_ready%0d", i), in_ready_1, 1);
      step();
    end

    // reset mid-stall on W=4
    out_ready = 0; in_valid = 1; op = 3'd7; a = 4'b0101;
    step();
    in_valid = 0;
    step();
    check("pre_rst_stall", out_valid, 1);
    check("pre_rst_y", y, 4'b0101);
    rst = 1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_y_op", y_op, 0);
    step();
    rst = 0;
    out_ready = 1;
    #1;
    in_valid = 1; op = 3'd6; a = 4'b1100; b = 4'b1010;
    step();
    in_valid = 0;
    check("post_rst_y", y, 4'b1001);
    check("post_rst_valid", out_valid, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
